// File: rtl/mux_arb_pkg.sv
// Shared definitions for the mux_arbiter4 round-robin mux arbiter.
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // One-hot vector with bit `idx` set.
    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux_arbiter4_rr_pick.sv
// rr_pick: combinational rotating priority encoder.
// Picks the first set bit of req in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    // Walk the requesters starting at ptr; the first hit wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        any = 1'b0;
        idx = ptr;
        for (int i = 0; i < N_REQ; i++) begin
            if (!any && req[ptr + SEL_W'(i)]) begin
                any = 1'b1;
                idx = ptr + SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/mux_arbiter4.sv
// mux_arbiter4: round-robin arbiter owning the select of a shared W-bit 4:1 mux.
// Grant and select are registered; y is decoded from the registered select.
// Optional feature: define MUX_ARB_HOLD_LIMIT_EN to cap an owner at MAX_HOLD
// consecutive cycles while others are waiting.
module mux_arbiter4
    import mux_arb_pkg::*;
#(
    parameter int W        = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [W-1:0]     d0,
    input  logic [W-1:0]     d1,
    input  logic [W-1:0]     d2,
    input  logic [W-1:0]     d3,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             valid,
    output logic [W-1:0]     y
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("mux_arbiter4: MAX_HOLD must be in 2..255");
    end

    state_e           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;

    logic [N_REQ-1:0] pick_req;
    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;
    logic             keep;
    logic             new_grant;

    // In GRANT the owner is masked out so the encoder yields the handover winner.
    assign pick_req = (state_q == ST_GRANT) ? (req & ~onehot(sel_q)) : req;

    rr_pick u_rr_pick (
        .req (pick_req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

`ifdef MUX_ARB_HOLD_LIMIT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       at_limit;

    assign at_limit = (hold_cnt_q == HOLD_LAST);
    // Owner keeps the grant unless it has used its quota and someone is waiting.
    assign keep     = req[sel_q] && !(at_limit && pick_any);

    // Hold counter: cleared on a new grant, counts GRANT cycles, wraps at the limit.
    always_comb begin
        hold_cnt_d = 8'd0;
        if (!new_grant && state_q == ST_GRANT && !at_limit) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
        end
    end

    // Hold counter register.
    always_ff @(posedge clk) begin
        if (rst) hold_cnt_q <= 8'd0;
        else     hold_cnt_q <= hold_cnt_d;
    end
`else
    // Without the hold limit the owner keeps the grant as long as it requests.
    assign keep = req[sel_q];
`endif

    // Next-state decode: new grant from IDLE, hold, handover or release to IDLE.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        gnt_d     = gnt_q;
        new_grant = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                new_grant = pick_any;
            end
            ST_GRANT: begin
                if (!keep) begin
                    if (pick_any) begin
                        new_grant = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
        if (new_grant) begin
            state_d = ST_GRANT;
            gnt_d   = onehot(pick_idx);
            sel_d   = pick_idx;
            ptr_d   = pick_idx + SEL_W'(1);
        end
    end

    // State and registered outputs; synchronous reset drops any grant at once.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt   = gnt_q;
    assign sel   = sel_q;
    assign valid = |gnt_q;

    // Output mux driven by the registered select; forced to zero with no owner.
    always_comb begin
        y = '0;
        if (valid) begin
            unique case (sel_q)
                2'd0:    y = d0;
                2'd1:    y = d1;
                2'd2:    y = d2;
                default: y = d3;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_arbiter4.sv
// Scoreboard bench for mux_arbiter4: the stimulus process pushes the
// hand-computed outputs expected after each clock edge; a monitor pops and
// compares them on the falling edge.
module tb_mux_arbiter4;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req = 4'b0000;
    logic [W-1:0] d0  = 4'h1;
    logic [W-1:0] d1  = 4'h2;
    logic [W-1:0] d2  = 4'h4;
    logic [W-1:0] d3  = 4'h8;
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic         valid;
    logic [W-1:0] y;

    mux_arbiter4 #(.W(W), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .d0    (d0),
        .d1    (d1),
        .d2    (d2),
        .d3    (d3),
        .gnt   (gnt),
        .sel   (sel),
        .valid (valid),
        .y     (y)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        int           tag;
        logic [3:0]   gnt;
        logic [1:0]   sel;
        logic         valid;
        logic [W-1:0] y;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   tag     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] data_of(input logic [1:0] s);
        case (s)
            2'd0:    return d0;
            2'd1:    return d1;
            2'd2:    return d2;
            default: return d3;
        endcase
    endfunction

    // Monitor: compare every expectation whose cycle has been reached.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_tests++;
            if (gnt !== e.gnt || sel !== e.sel || valid !== e.valid || y !== e.y) begin
                n_fail++;
                $display("FAIL step %0d: got gnt=%b sel=%0d valid=%b y=%h, expected gnt=%b sel=%0d valid=%b y=%h",
                         e.tag, gnt, sel, valid, y, e.gnt, e.sel, e.valid, e.y);
            end
        end
    end

    // Drive one cycle of inputs and record what the outputs must be after the edge.
    task automatic step(input logic r, input logic [3:0] rq,
                        input logic [3:0] eg, input logic [1:0] es);
        exp_t e;
        rst = r;
        req = rq;
        tag++;
        e.cyc   = cyc + 1;
        e.tag   = tag;
        e.gnt   = eg;
        e.sel   = es;
        e.valid = |eg;
        e.y     = (|eg) ? data_of(es) : '0;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset values
        step(1'b1, 4'b0000, 4'b0000, 2'd0);
        step(1'b1, 4'b0000, 4'b0000, 2'd0);

        // Single request from IDLE, then release to IDLE
        step(1'b0, 4'b0001, 4'b0001, 2'd0);
        step(1'b0, 4'b0000, 4'b0000, 2'd0);

        // Full rotation with back-to-back handovers, ptr restarted at 0
        step(1'b1, 4'b0000, 4'b0000, 2'd0);
        step(1'b0, 4'b1111, 4'b0001, 2'd0);
        step(1'b0, 4'b1110, 4'b0010, 2'd1);
        step(1'b0, 4'b1101, 4'b0100, 2'd2);
        step(1'b0, 4'b1011, 4'b1000, 2'd3);
        step(1'b0, 4'b0111, 4'b0001, 2'd0);

        // Owner 1 holds while requester 2 waits
        step(1'b0, 4'b0010, 4'b0010, 2'd1);
`ifdef MUX_ARB_HOLD_LIMIT_EN
        step(1'b0, 4'b0110, 4'b0010, 2'd1);
        step(1'b0, 4'b0110, 4'b0010, 2'd1);
        step(1'b0, 4'b0110, 4'b0010, 2'd1);
        step(1'b0, 4'b0110, 4'b0100, 2'd2);
        step(1'b0, 4'b0110, 4'b0100, 2'd2);
        step(1'b0, 4'b0000, 4'b0000, 2'd2);
`else
        step(1'b0, 4'b0110, 4'b0010, 2'd1);
        step(1'b0, 4'b0110, 4'b0010, 2'd1);
        step(1'b0, 4'b0110, 4'b0010, 2'd1);
        step(1'b0, 4'b0110, 4'b0010, 2'd1);
        step(1'b0, 4'b0110, 4'b0010, 2'd1);
        step(1'b0, 4'b0000, 4'b0000, 2'd1);
`endif

        // Owner 3 releases with nothing pending: sel holds 3, y forced to 0
        step(1'b0, 4'b1000, 4'b1000, 2'd3);
        step(1'b0, 4'b0000, 4'b0000, 2'd3);

        // Last owner 2 leaves ptr=3, so index 0 beats index 1
        step(1'b0, 4'b0100, 4'b0100, 2'd2);
        step(1'b0, 4'b0000, 4'b0000, 2'd2);
        step(1'b0, 4'b0011, 4'b0001, 2'd0);

        // Reset mid-grant, requests ignored during reset, ptr back to 0
        step(1'b0, 4'b0100, 4'b0100, 2'd2);
        step(1'b1, 4'b0100, 4'b0000, 2'd0);
        step(1'b1, 4'b1111, 4'b0000, 2'd0);
        step(1'b0, 4'b1001, 4'b0001, 2'd0);
        step(1'b0, 4'b0000, 4'b0000, 2'd0);

        // Let the monitor drain; a stuck queue is itself a failure
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
